// File: rtl/cache_mem_read_arbiter.sv
// Shares one AXI read address/data channel pair between the I-cache and D-cache refill ports.
// Latency: one IDLE bubble cycle per grant, then address and data pass straight through to the owner.
// Backpressure: memory arready and the owner's rready pass straight through; the losing requester waits with arready low.
module cache_mem_read_arbiter #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [LEN_WIDTH-1:0]  i_arlen,
    input  logic [ID_WIDTH-1:0]   i_arid,
    output logic                  i_arready,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_rready,

    input  logic                  d_arvalid,
    input  logic [ADDR_WIDTH-1:0] d_araddr,
    input  logic [LEN_WIDTH-1:0]  d_arlen,
    input  logic [ID_WIDTH-1:0]   d_arid,
    output logic                  d_arready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    input  logic                  d_rready,

    output logic                  m_arvalid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [LEN_WIDTH-1:0]  m_arlen,
    output logic [ID_WIDTH-1:0]   m_arid,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state;
    logic                 owner_d;   // 1: D-cache owns the channel, 0: I-cache
    logic                 prio_d;    // 1: D-cache wins a simultaneous request
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] beat_cnt;

    logic                 grant_d;
    logic [LEN_WIDTH-1:0] req_len;
    logic                 ar_hs;
    logic                 r_hs;
    logic                 last_beat;

    assign grant_d   = d_arvalid & (~i_arvalid | prio_d);
    assign req_len   = grant_d ? d_arlen : i_arlen;
    assign ar_hs     = (state == ADDR) & m_arvalid & m_arready;
    assign r_hs      = (state == DATA) & m_rvalid & m_rready;
    // Burst end is decided purely by the beat count; RLAST/RID are not consulted.
    assign last_beat = (beat_cnt == (len_r - LEN_ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            prio_d   <= 1'b1;
            len_r    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_arvalid | d_arvalid) begin
                        owner_d <= grant_d;
                        len_r   <= (req_len == '0) ? LEN_ONE : req_len;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            prio_d   <= ~owner_d;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arid    = '0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        m_rready  = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        if (state == ADDR) begin
            if (owner_d) begin
                m_arvalid = d_arvalid;
                m_araddr  = d_araddr;
                m_arlen   = d_arlen;
                m_arid    = d_arid;
                d_arready = m_arready;
            end else begin
                m_arvalid = i_arvalid;
                m_araddr  = i_araddr;
                m_arlen   = i_arlen;
                m_arid    = i_arid;
                i_arready = m_arready;
            end
        end

        // Stray memory beats outside DATA are neither accepted nor forwarded.
        if (state == DATA) begin
            if (owner_d) begin
                d_rvalid = m_rvalid;
                d_rdata  = m_rdata;
                m_rready = d_rready;
            end else begin
                i_rvalid = m_rvalid;
                i_rdata  = m_rdata;
                m_rready = i_rready;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_read_arbiter.sv
// Directed bench for cache_mem_read_arbiter with immediate-assertion checks.
module tb_cache_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_arvalid, d_arvalid;
    logic [25:0] i_araddr, d_araddr, m_araddr;
    logic [7:0]  i_arlen, d_arlen, m_arlen;
    logic [3:0]  i_arid, d_arid, m_arid;
    logic        i_arready, d_arready;
    logic        i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata, m_rdata;
    logic        i_rready, d_rready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_mem_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arid(i_arid),
        .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arid(d_arid),
        .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rready(d_rready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " m_arvalid"}, 32'(m_arvalid), 0);
        chk({tag, " i_arready"}, 32'(i_arready), 0);
        chk({tag, " d_arready"}, 32'(d_arready), 0);
        chk({tag, " i_rvalid"},  32'(i_rvalid),  0);
        chk({tag, " d_rvalid"},  32'(d_rvalid),  0);
        chk({tag, " m_rready"},  32'(m_rready),  0);
        chk({tag, " i_rdata"},   i_rdata,        0);
        chk({tag, " d_rdata"},   d_rdata,        0);
    endtask

    // Called with the DUT in ADDR: checks the pass-through, completes the handshake, enters DATA.
    task automatic addr_phase(input string tag, input bit is_d, input logic [25:0] addr,
                              input logic [7:0] len);
        m_arready = 1'b1;
        #1;
        chk({tag, " m_arvalid"}, 32'(m_arvalid), 1);
        chk({tag, " m_araddr"},  32'(m_araddr),  32'(addr));
        chk({tag, " m_arlen"},   32'(m_arlen),   32'(len));
        chk({tag, " owner arready"}, 32'(is_d ? d_arready : i_arready), 1);
        chk({tag, " other arready"}, 32'(is_d ? i_arready : d_arready), 0);
        tick();
        if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    endtask

    // Called with the DUT in DATA: delivers n beats, then checks the burst has ended.
    task automatic beats(input string tag, input bit is_d, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(k);
            i_rready = ~is_d;
            d_rready = is_d;
            #1;
            chk({tag, " owner rvalid"}, 32'(is_d ? d_rvalid : i_rvalid), 1);
            chk({tag, " owner rdata"},  is_d ? d_rdata : i_rdata, base + 32'(k));
            chk({tag, " other rvalid"}, 32'(is_d ? i_rvalid : d_rvalid), 0);
            chk({tag, " m_rready"},     32'(m_rready), 1);
            tick();
        end
        #1;
        chk({tag, " end m_rready"},     32'(m_rready), 0);
        chk({tag, " end owner rvalid"}, 32'(is_d ? d_rvalid : i_rvalid), 0);
        m_rvalid = 1'b0;
        i_rready = 1'b0;
        d_rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_arid = 4'h1; i_rready = 1'b0;
        d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arid = 4'h2; d_rready = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD;
        tick();
        tick();
        chk_all_zero("reset");
        m_rvalid = 1'b0;
        rst_n = 1'b1;

        // D alone, 4 beats
        d_arvalid = 1'b1; d_araddr = 26'h0000100; d_arlen = 8'd4; m_arready = 1'b1;
        #1;
        chk("idle bubble m_arvalid", 32'(m_arvalid), 0);
        chk("idle bubble d_arready", 32'(d_arready), 0);
        tick();
        addr_phase("t1 addr", 1'b1, 26'h0000100, 8'd4);
        beats("t1 data", 1'b1, 4, 32'hA0);

        // Simultaneous requests after reset: D first, then I, then D again
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i_arvalid = 1'b1; i_araddr = 26'h0000200; i_arlen = 8'd2;
        d_arvalid = 1'b1; d_araddr = 26'h0000300; d_arlen = 8'd2;
        tick();
        addr_phase("t2 d first", 1'b1, 26'h0000300, 8'd2);
        #1;
        chk("t2 i waits", 32'(i_arready), 0);
        beats("t2 d data", 1'b1, 2, 32'hC0);
        chk("t2 bubble m_arvalid", 32'(m_arvalid), 0);
        chk("t2 bubble i_arready", 32'(i_arready), 0);
        tick();
        addr_phase("t2 i second", 1'b0, 26'h0000200, 8'd2);
        beats("t2 i data", 1'b0, 2, 32'hD0);
        i_arvalid = 1'b1; d_arvalid = 1'b1;
        tick();
        addr_phase("t2 d again", 1'b1, 26'h0000300, 8'd2);
        i_arvalid = 1'b0;
        beats("t2 d again data", 1'b1, 2, 32'hE0);

        // Memory arready held low for 5 cycles
        i_arvalid = 1'b1; i_araddr = 26'h0000400; i_arlen = 8'd1; m_arready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3 stall m_arvalid", 32'(m_arvalid), 1);
            chk("t3 stall m_araddr",  32'(m_araddr),  32'h400);
            chk("t3 stall i_arready", 32'(i_arready), 0);
            tick();
        end
        addr_phase("t3 handshake", 1'b0, 26'h0000400, 8'd1);
        beats("t3 data", 1'b0, 1, 32'h11);

        // Owner stalls rready for 3 cycles mid-burst
        d_arvalid = 1'b1; d_araddr = 26'h0000500; d_arlen = 8'd4;
        tick();
        addr_phase("t4 addr", 1'b1, 26'h0000500, 8'd4);
        beats_partial_t4: begin
            for (int k = 0; k < 2; k++) begin
                m_rvalid = 1'b1; m_rdata = 32'hB0 + 32'(k); d_rready = 1'b1;
                #1;
                chk("t4 beat rdata", d_rdata, 32'hB0 + 32'(k));
                tick();
            end
            d_rready = 1'b0; m_rdata = 32'hB2;
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("t4 stall m_rready", 32'(m_rready), 0);
                chk("t4 stall d_rvalid", 32'(d_rvalid), 1);
                tick();
            end
        end
        beats("t4 resume", 1'b1, 2, 32'hB2);

        // Reset during DATA after 2 of 4 beats
        d_arvalid = 1'b1; d_araddr = 26'h0000600; d_arlen = 8'd4;
        tick();
        addr_phase("t5 addr", 1'b1, 26'h0000600, 8'd4);
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1; m_rdata = 32'hF0 + 32'(k); d_rready = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk_all_zero("t5 mid-burst reset");
        rst_n = 1'b1; m_rvalid = 1'b0; d_rready = 1'b0;
        i_arvalid = 1'b1; i_araddr = 26'h0000700; i_arlen = 8'd1;
        d_arvalid = 1'b1; d_araddr = 26'h0000800; d_arlen = 8'd1;
        tick();
        addr_phase("t5 ptr reset to d", 1'b1, 26'h0000800, 8'd1);
        beats("t5 d data", 1'b1, 1, 32'h21);
        tick();
        addr_phase("t5 fresh i", 1'b0, 26'h0000700, 8'd1);
        beats("t5 i data", 1'b0, 1, 32'h31);

        // arlen=0 is a single beat, then a stray beat in IDLE
        i_arvalid = 1'b1; i_araddr = 26'h0000900; i_arlen = 8'd0;
        tick();
        addr_phase("t6 len0", 1'b0, 26'h0000900, 8'd0);
        beats("t6 len0 data", 1'b0, 1, 32'h41);
        m_rvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t6 stray m_rready", 32'(m_rready), 0);
            chk("t6 stray i_rvalid", 32'(i_rvalid), 0);
            chk("t6 stray d_rvalid", 32'(d_rvalid), 0);
            tick();
        end
        m_rvalid = 1'b0; i_rready = 1'b0; d_rready = 1'b0;

        // Maximum-length burst of 255 beats
        d_arvalid = 1'b1; d_araddr = 26'h0000A00; d_arlen = 8'd255;
        tick();
        addr_phase("t7 max", 1'b1, 26'h0000A00, 8'd255);
        beats("t7 max data", 1'b1, 255, 32'h1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
